// File: rtl/dual_sram_reader.sv
// Ping-pong SRAM read controller: drains each full bank in strict 0,1,0,1 order onto a valid/ready stream; optional READ_CKSUM_EN adds a per-bank XOR checksum.
// Latency: first word valid 2 cycles after bank_full is seen in IDLE, then one word per cycle with the incoming SRAM word bypassing an empty skid.
// Backpressure: 2 credits cover reads in flight plus skid occupancy, so cen stalls on out_ready=0 with no combinational path from out_ready.
module dual_sram_reader #(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        bank_full,
  output logic [1:0]        bank_release,
  output logic              sram_cen,
  output logic              sram_bank,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
`ifdef READ_CKSUM_EN
  output logic [DATA_W-1:0] cksum,
  output logic              cksum_valid,
`endif
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              out_bank
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, RELEASE} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic              last;
    logic              bank;
  } entry_t;

  state_t            state;
  logic              cur_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        credits;

  logic              inflight_vld;
  logic              inflight_last;
  logic              inflight_bank;

  entry_t            skid [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        skid_cnt;

  entry_t            incoming;
  entry_t            head;
  logic              issue;
  logic              xfer;
  logic              push;
  logic              pop;
  logic              last_xfer;

  assign issue     = (state == READ) && (credits != 2'd0);
  assign sram_cen  = issue;
  assign sram_bank = cur_bank;
  assign sram_addr = rd_addr;

  // The word arriving from the SRAM goes straight out when the skid is empty,
  // which is what lets two credits sustain one word per cycle.
  always_comb begin
    incoming = {sram_rdata, inflight_last, inflight_bank};
    head     = '0;
    if (skid_cnt != 2'd0) begin
      head = skid[rd_ptr];
    end else if (inflight_vld) begin
      head = incoming;
    end
  end

  assign out_valid = (skid_cnt != 2'd0) || inflight_vld;
  assign out_data  = head.dat;
  assign out_last  = head.last;
  assign out_bank  = head.bank;

  assign xfer      = out_valid && out_ready;
  assign push      = inflight_vld && !((skid_cnt == 2'd0) && xfer);
  assign pop       = xfer && (skid_cnt != 2'd0);
  assign last_xfer = xfer && out_last && (state == DRAIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cur_bank      <= 1'b0;
      rd_addr       <= '0;
      credits       <= 2'd2;
      inflight_vld  <= 1'b0;
      inflight_last <= 1'b0;
      inflight_bank <= 1'b0;
      skid[0]       <= '0;
      skid[1]       <= '0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      skid_cnt      <= 2'd0;
      bank_release  <= 2'b00;
    end else begin
      credits       <= credits - {1'b0, issue} + {1'b0, xfer};
      inflight_vld  <= issue;
      inflight_last <= (rd_addr == LAST_ADDR);
      inflight_bank <= cur_bank;

      if (push) begin
        skid[wr_ptr] <= incoming;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      skid_cnt <= skid_cnt + {1'b0, push} - {1'b0, pop};

      bank_release <= 2'b00;
      case (state)
        IDLE: begin
          if (bank_full[cur_bank]) begin
            state <= READ;
          end
        end
        READ: begin
          if (issue) begin
            if (rd_addr == LAST_ADDR) begin
              state <= DRAIN;
            end else begin
              rd_addr <= rd_addr + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (last_xfer) begin
            state                  <= RELEASE;
            bank_release[cur_bank] <= 1'b1;
          end
        end
        RELEASE: begin
          cur_bank <= ~cur_bank;
          rd_addr  <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef READ_CKSUM_EN
  logic [DATA_W-1:0] cksum_acc;

  // Final value folds in the last word, so cksum lines up with the release pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cksum_acc   <= '0;
      cksum       <= '0;
      cksum_valid <= 1'b0;
    end else begin
      cksum_valid <= 1'b0;
      if (last_xfer) begin
        cksum       <= cksum_acc ^ out_data;
        cksum_valid <= 1'b1;
        cksum_acc   <= '0;
      end else if (xfer) begin
        cksum_acc <= cksum_acc ^ out_data;
      end
    end
  end
`endif

endmodule
